// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side bundle of the hazard unit: register numbers and control
// bits coming from the datapath, stall/flush/forward controls going back.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
  logic [REG_AW-1:0] writeregE, writeregM, writeregW;
  logic              regwriteE, regwriteM, regwriteW;
  logic              memtoregE, memtoregM;
  logic              branchD, divE, excflush;
  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD;
  logic              stallF, stallD, stallE;
  logic              flushD, flushE, flushM;
  logic              div_busy, div_done;
  logic [CNT_W-1:0]  stall_cycles;

  // Datapath side: drives pipeline status, receives controls.
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, excflush,
    input  forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, flushD, flushE, flushM,
           div_busy, div_done, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, excflush,
    output forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, flushD, flushE, flushM,
           div_busy, div_done, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage MIPS pipeline: operand forwarding to E and to the
// D-stage branch comparator, load-use / branch-operand stalls, a multi-cycle
// divide sequencer that freezes F/D/E, exception flush, and a saturating
// count of cycles in which fetch was stalled.
module hazard_unit_mc #(
  parameter int REG_AW      = 5,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              rst_n,
  hazard_unit_mc_if.slave  hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_LATENCY - 1);

  divState_t        stateReg, stateNext;
  logic [7:0]       countReg, countNext;
  logic [CNT_W-1:0] stallCyclesReg;

  logic       lwStall, brStall;
  logic       stallFInt, stallDInt, stallEInt;
  logic       flushDInt, flushEInt, flushMInt;
  logic       divBusyInt, divDoneInt;
  logic [1:0] fwdAE, fwdBE;
  logic       fwdAD, fwdBD;

  // Divider sequencer state and countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  // Forwarding selects; M is younger than W so it wins. Register 0 never forwards.
  always_comb begin
    fwdAE = 2'b00;
    fwdBE = 2'b00;
    if (hz.rsE != '0 && hz.rsE == hz.writeregM && hz.regwriteM)      fwdAE = 2'b10;
    else if (hz.rsE != '0 && hz.rsE == hz.writeregW && hz.regwriteW) fwdAE = 2'b01;
    if (hz.rtE != '0 && hz.rtE == hz.writeregM && hz.regwriteM)      fwdBE = 2'b10;
    else if (hz.rtE != '0 && hz.rtE == hz.writeregW && hz.regwriteW) fwdBE = 2'b01;
    fwdAD = (hz.rsD != '0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    fwdBD = (hz.rtD != '0) && (hz.rtD == hz.writeregM) && hz.regwriteM;
  end

  // Load-use and branch-operand hazard detection.
  always_comb begin
    lwStall = hz.memtoregE && (hz.rtE != '0) &&
              ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE));
    brStall = hz.branchD &&
              ((hz.regwriteE && (hz.writeregE != '0) &&
                ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
               (hz.memtoregM && (hz.writeregM != '0) &&
                ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
  end

  // Divider next state plus prioritised stall/flush controls.
  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    stallFInt  = 1'b0;
    stallDInt  = 1'b0;
    stallEInt  = 1'b0;
    flushDInt  = 1'b0;
    flushEInt  = 1'b0;
    flushMInt  = 1'b0;
    divBusyInt = (stateReg == RUN);
    divDoneInt = (stateReg == DONE);

    case (stateReg)
      IDLE: begin
        if (hz.divE) begin
          stateNext = RUN;
          countNext = DIV_LOAD;
        end
      end
      RUN: begin
        if (countReg == 8'd0) stateNext = DONE;
        else                  countNext = countReg - 8'd1;
      end
      DONE:    stateNext = IDLE;  // the finished div is leaving E; divE ignored
      default: stateNext = IDLE;
    endcase

    // An exception aborts any divide in flight without a done pulse.
    if (hz.excflush) begin
      stateNext = IDLE;
      countNext = 8'd0;
    end

    if (hz.excflush) begin
      flushDInt = 1'b1;
      flushEInt = 1'b1;
      flushMInt = 1'b1;
    end else if (stateReg == RUN || (stateReg == IDLE && hz.divE)) begin
      // E is frozen to keep the divide; M gets a bubble each held cycle.
      stallFInt = 1'b1;
      stallDInt = 1'b1;
      stallEInt = 1'b1;
      flushMInt = 1'b1;
    end else if (lwStall || brStall) begin
      stallFInt = 1'b1;
      stallDInt = 1'b1;
      flushEInt = 1'b1;
    end

    // All controls are quiet while reset is asserted.
    if (!rst_n) begin
      stallFInt  = 1'b0;
      stallDInt  = 1'b0;
      stallEInt  = 1'b0;
      flushDInt  = 1'b0;
      flushEInt  = 1'b0;
      flushMInt  = 1'b0;
      divBusyInt = 1'b0;
      divDoneInt = 1'b0;
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stallCyclesReg <= '0;
    else if (stallFInt && stallCyclesReg != '1)   stallCyclesReg <= stallCyclesReg + 1'b1;
  end

  assign hz.forwardAE    = rst_n ? fwdAE : 2'b00;
  assign hz.forwardBE    = rst_n ? fwdBE : 2'b00;
  assign hz.forwardAD    = rst_n & fwdAD;
  assign hz.forwardBD    = rst_n & fwdBD;
  assign hz.stallF       = stallFInt;
  assign hz.stallD       = stallDInt;
  assign hz.stallE       = stallEInt;
  assign hz.flushD       = flushDInt;
  assign hz.flushE       = flushEInt;
  assign hz.flushM       = flushMInt;
  assign hz.div_busy     = divBusyInt;
  assign hz.div_done     = divDoneInt;
  assign hz.stall_cycles = stallCyclesReg;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios followed by
// randomized pipeline traffic, all compared against a behavioural model.
module tb_hazard_unit_mc;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Model state: remaining RUN cycles, done pulse pending, stall count.
  int mBusy = 0;
  bit mDone = 0;
  int mStall = 0;
  bit expStallF;

  hazard_unit_mc_if #(.REG_AW(AW), .CNT_W(CW)) hzIf ();

  hazard_unit_mc #(.REG_AW(AW), .DIV_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hzIf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clearInputs();
    hzIf.rsD = '0; hzIf.rtD = '0; hzIf.rsE = '0; hzIf.rtE = '0;
    hzIf.writeregE = '0; hzIf.writeregM = '0; hzIf.writeregW = '0;
    hzIf.regwriteE = 0; hzIf.regwriteM = 0; hzIf.regwriteW = 0;
    hzIf.memtoregE = 0; hzIf.memtoregM = 0;
    hzIf.branchD = 0; hzIf.divE = 0; hzIf.excflush = 0;
  endtask

  function automatic logic [1:0] fwdRule(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (hzIf.regwriteM && src == hzIf.writeregM) return 2'b10;
    if (hzIf.regwriteW && src == hzIf.writeregW) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the model; inputs must already be settled.
  task automatic checkAll();
    bit lw, br, inRun, holdDiv;
    bit eF, eD, eE, fD, fE, fM;
    logic [1:0] eAE, eBE;
    bit eAD, eBD;
    lw = hzIf.memtoregE && hzIf.rtE != 0 &&
         (hzIf.rsD == hzIf.rtE || hzIf.rtD == hzIf.rtE);
    br = hzIf.branchD &&
         ((hzIf.regwriteE && hzIf.writeregE != 0 &&
           (hzIf.writeregE == hzIf.rsD || hzIf.writeregE == hzIf.rtD)) ||
          (hzIf.memtoregM && hzIf.writeregM != 0 &&
           (hzIf.writeregM == hzIf.rsD || hzIf.writeregM == hzIf.rtD)));
    inRun   = (mBusy > 0);
    holdDiv = inRun || (!mDone && hzIf.divE);
    {eF, eD, eE, fD, fE, fM} = '0;
    if (hzIf.excflush)  {fD, fE, fM} = 3'b111;
    else if (holdDiv)   {eF, eD, eE, fM} = 4'b1111;
    else if (lw || br)  {eF, eD, fE} = 3'b111;
    eAE = fwdRule(hzIf.rsE);
    eBE = fwdRule(hzIf.rtE);
    eAD = hzIf.rsD != 0 && hzIf.regwriteM && hzIf.rsD == hzIf.writeregM;
    eBD = hzIf.rtD != 0 && hzIf.regwriteM && hzIf.rtD == hzIf.writeregM;
    if (!rst_n) begin
      {eF, eD, eE, fD, fE, fM, eAD, eBD} = '0;
      eAE = 0; eBE = 0; inRun = 0;
    end
    expStallF = eF;
    chk("forwardAE", 32'(hzIf.forwardAE), 32'(eAE));
    chk("forwardBE", 32'(hzIf.forwardBE), 32'(eBE));
    chk("forwardAD", 32'(hzIf.forwardAD), 32'(eAD));
    chk("forwardBD", 32'(hzIf.forwardBD), 32'(eBD));
    chk("stallF", 32'(hzIf.stallF), 32'(eF));
    chk("stallD", 32'(hzIf.stallD), 32'(eD));
    chk("stallE", 32'(hzIf.stallE), 32'(eE));
    chk("flushD", 32'(hzIf.flushD), 32'(fD));
    chk("flushE", 32'(hzIf.flushE), 32'(fE));
    chk("flushM", 32'(hzIf.flushM), 32'(fM));
    chk("div_busy", 32'(hzIf.div_busy), 32'(inRun));
    chk("div_done", 32'(hzIf.div_done), 32'(mDone && rst_n));
    chk("stall_cycles", 32'(hzIf.stall_cycles), 32'(mStall));
    $display("[TB] cyc=%0d stallF=%0b stallE=%0b flushE=%0b flushM=%0b busy=%0b done=%0b fwdE=%0d/%0d cnt=%0d",
             cyc, hzIf.stallF, hzIf.stallE, hzIf.flushE, hzIf.flushM,
             hzIf.div_busy, hzIf.div_done, hzIf.forwardAE, hzIf.forwardBE, hzIf.stall_cycles);
  endtask

  // Advance one clock edge and the model with it.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (expStallF && mStall < SAT) mStall++;
      if (hzIf.excflush)  begin mBusy = 0; mDone = 0; end
      else if (mDone)      mDone = 0;
      else if (mBusy > 0) begin mBusy--; if (mBusy == 0) mDone = 1; end
      else if (hzIf.divE)  mBusy = LAT;
    end
    #1;
  endtask

  task automatic step();
    #1;
    checkAll();
    tick();
  endtask

  initial begin
    int startCnt;
    rst_n = 1'b0;
    clearInputs();
    // Inputs that would forward/stall if not in reset.
    hzIf.rsE = 5'd3; hzIf.writeregM = 5'd3; hzIf.regwriteM = 1; hzIf.divE = 1;
    #2;
    checkAll();
    chk("reset_fwdAE", 32'(hzIf.forwardAE), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearInputs();

    // Forward from M to both E operands.
    hzIf.rsE = 5'd3; hzIf.rtE = 5'd3; hzIf.writeregM = 5'd3; hzIf.regwriteM = 1;
    #1; chk("fwdM_AE", 32'(hzIf.forwardAE), 32'd2); chk("fwdM_BE", 32'(hzIf.forwardBE), 32'd2);
    step();
    // Only W holds r3.
    hzIf.regwriteM = 0; hzIf.writeregW = 5'd3; hzIf.regwriteW = 1;
    #1; chk("fwdW_AE", 32'(hzIf.forwardAE), 32'd1);
    step();
    // Destination r0 never forwards.
    hzIf.rsE = 0; hzIf.rtE = 0; hzIf.writeregM = 0; hzIf.regwriteM = 1; hzIf.writeregW = 0;
    #1; chk("fwd_r0", 32'(hzIf.forwardAE), 32'd0);
    step();
    clearInputs();

    // Load-use: lw r5 in E, D reads r5.
    hzIf.memtoregE = 1; hzIf.rtE = 5'd5; hzIf.rsD = 5'd5;
    #1; chk("lw_stallF", 32'(hzIf.stallF), 32'd1); chk("lw_flushE", 32'(hzIf.flushE), 32'd1);
    step();
    hzIf.rtE = 0; hzIf.rsD = 0;
    #1; chk("lw_r0", 32'(hzIf.stallF), 32'd0);
    step();
    clearInputs();

    // Branch on r4 with add r4 in E, then in M.
    hzIf.branchD = 1; hzIf.rsD = 5'd4; hzIf.regwriteE = 1; hzIf.writeregE = 5'd4;
    #1; chk("br_stallD", 32'(hzIf.stallD), 32'd1);
    step();
    hzIf.regwriteE = 0; hzIf.writeregE = 0; hzIf.regwriteM = 1; hzIf.writeregM = 5'd4;
    #1; chk("br_fwdAD", 32'(hzIf.forwardAD), 32'd1); chk("br_nostall", 32'(hzIf.stallF), 32'd0);
    step();
    clearInputs();

    // Full divide: stall while IDLE+divE and for every RUN cycle, then done.
    startCnt = mStall;
    hzIf.divE = 1;
    repeat (LAT + 2) step();
    hzIf.divE = 0;
    step();
    chk("div_stall_count", 32'(hzIf.stall_cycles),
        32'((startCnt + LAT + 1 > SAT) ? SAT : startCnt + LAT + 1));

    // Exception in the second RUN cycle aborts the divide.
    hzIf.divE = 1;
    step(); step();
    hzIf.excflush = 1;
    step();
    hzIf.excflush = 0; hzIf.divE = 0;
    #1; chk("exc_no_busy", 32'(hzIf.div_busy), 32'd0); chk("exc_no_done", 32'(hzIf.div_done), 32'd0);
    step();

    // Asynchronous reset in the middle of a divide.
    hzIf.divE = 1;
    step(); step();
    #2 rst_n = 1'b0;
    mBusy = 0; mDone = 0; mStall = 0;
    #1; checkAll();
    chk("rst_mid_stallE", 32'(hzIf.stallE), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; hzIf.divE = 0;

    // Randomized traffic; the divide is held in E while it runs.
    for (int i = 0; i < 300; i++) begin
      hzIf.rsD = AW'($urandom_range(0, 3)); hzIf.rtD = AW'($urandom_range(0, 3));
      hzIf.rsE = AW'($urandom_range(0, 3)); hzIf.rtE = AW'($urandom_range(0, 3));
      hzIf.writeregE = AW'($urandom_range(0, 3));
      hzIf.writeregM = AW'($urandom_range(0, 3));
      hzIf.writeregW = AW'($urandom_range(0, 3));
      hzIf.regwriteE = 1'($urandom); hzIf.regwriteM = 1'($urandom); hzIf.regwriteW = 1'($urandom);
      hzIf.memtoregE = 1'($urandom); hzIf.memtoregM = 1'($urandom); hzIf.branchD = 1'($urandom);
      hzIf.divE = (mBusy > 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      hzIf.excflush = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
